uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares one `uart_tx` serial transmitter among `NUM_REQ` byte producers. Each requester offers a byte over a valid/ready handshake. The arbiter grants one requester at a time and optionally sends a channel-tag byte ahead of the payload byte. It sequences `tx_start` against the transmitter's `tx_busy`/`tx_done`, and a watchdog aborts a frame if the transmitter never completes.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 8: byte width; must match `uart_tx`.
- `TAG_EN`, 1: 1 sends tag byte `TAG_BASE | grant_id` before each payload byte; 0 sends payload only.
- `TAG_BASE`, 8'hF0: tag prefix; the low `$clog2(NUM_REQ)` bits must be zero.
- `TIMEOUT`, 0: max cycles waiting for `tx_done` per byte; 0 disables the watchdog.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester byte valid; held until accepted.
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester i's byte at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  one-hot accept; transfer happens at the edge where valid&ready.
- `tx_start`  out  1  start pulse to `uart_tx`.
- `tx_data`  out  DATA_WIDTH  byte to `uart_tx`; stable from the `tx_start` cycle until `tx_done`.
- `tx_busy`  in  1  from `uart_tx`.
- `tx_done`  in  1  one-cycle completion pulse from `uart_tx`.
- `grant_id`  out  $clog2(NUM_REQ)  current/last granted requester.
- `active`  out  1  high from accept until the frame ends.
- `timeout_err`  out  1  one-cycle pulse on watchdog abort.

## Operation
- States:
  - IDLE: waiting for a request.
  - SEND_TAG: drive the tag byte.
  - WAIT_TAG: wait for the tag byte to complete.
  - SEND_DATA: drive the payload byte.
  - WAIT_DATA: wait for the payload byte to complete.
- Arbitration:
  - Combinational in IDLE only.
  - The winner is the first valid index at or after `rr_ptr`, wrapping modulo NUM_REQ.
  - `req_ready[winner]` = 1 only in IDLE; all other `req_ready` bits are 0, and all are 0 outside IDLE.
- On accept (IDLE and any valid):
  - capture the winner's byte into the payload register;
  - set `grant_id` = winner and `rr_ptr` = (winner+1) mod NUM_REQ;
  - set `active` = 1;
  - next state is SEND_TAG if TAG_EN, else SEND_DATA.
- SEND_x:
  - `tx_start` = !tx_busy (combinational); `tx_data` = tag or payload byte.
  - Leave to WAIT_x on the edge where `tx_start` = 1; stay while `tx_busy` = 1.
- WAIT_x:
  - On `tx_done`: WAIT_TAG goes to SEND_DATA; WAIT_DATA goes to IDLE with `active` = 0.
  - The watchdog counter clears on entering WAIT_x and increments each cycle.
  - When the count reaches TIMEOUT-1 without `tx_done`: pulse `timeout_err`, go to IDLE, `active` = 0.
  - The payload byte is dropped on abort and never retried.
- A `tx_done` seen outside WAIT_x is ignored.
- The `rr_ptr` update happens at accept, so an aborted requester still loses its turn.

## Timing
- Reset values:
  - `req_ready` = 0 (forced 0 while `rst_n` is low);
  - `tx_start` = 0, `tx_data` = 0, `grant_id` = 0, `active` = 0, `timeout_err` = 0;
  - state IDLE, `rr_ptr` = 0, watchdog count 0.
- Reset is asynchronous and may land mid-frame. The arbiter returns to IDLE immediately, and the in-flight `uart_tx` byte is the transmitter's concern.
- Latency, accept edge to first `tx_start`: 1 cycle if `tx_busy` = 0.
- Per-byte overhead beyond `uart_tx` frame time:
  - 1 cycle (SEND_x) after each `tx_done`;
  - plus 1 IDLE cycle between frames when requests are back-to-back.
- Accepts are spaced at least (TAG_EN+1) full UART frames apart; at most one byte is held internally.
- When valid and accept happen in the same cycle as an external `tx_busy` from another source, the arbiter waits in SEND_x without dropping the byte.

## Structure
- Shared package `uart_pkg`:
  - state enum `arb_state_t`;
  - `TAG_BASE` default;
  - function `rr_pick(valid, ptr)` returning index and found flag.
- Optional sub-module `rr_arbiter` (combinational picker plus pointer register), reusable by future UART RX demux/scheduling blocks.
- Everything else is inline in `uart_tx_arbiter`.

## Test plan
- NUM_REQ=4, TAG_EN=1, requester 2 sends 8'h5A with `uart_tx` attached and external baud tick -> line decodes 8'hF2 then 8'h5A; `req_ready[2]` is high exactly 1 cycle; `active` falls the cycle after the second `tx_done`.
- All four valid continuously with bytes 8'h10..8'h13 -> grant order 0,1,2,3,0; tags F0,F1,F2,F3,F0; no requester granted twice before all are served.
- TAG_EN=0, requester 1 only, 8'hFF -> single frame 8'hFF; `tx_start` pulses once, 1 cycle after accept.
- `tx_busy` forced high for 50 cycles after accept -> `tx_start` stays 0 and state stays SEND_TAG; `tx_start` pulses the first cycle `tx_busy` = 0; data is intact.
- TIMEOUT=100, `tx_done` tied 0 -> `timeout_err` pulses 100 cycles after entering WAIT_TAG; the next valid requester is granted afterwards.
- `rst_n` low during WAIT_DATA -> all outputs at reset values asynchronously; after release, a request from requester 0 is served first (`rr_ptr` = 0).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART scheduling types: arbiter state encoding, default tag prefix and a
// round-robin pick helper usable by any block that shares a UART among channels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_TAG,
    WAIT_TAG,
    SEND_DATA,
    WAIT_DATA
  } arb_state_t;

  localparam logic [7:0] DEFAULT_TAG_BASE = 8'hF0;
  localparam int         RR_MAX_REQ       = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of valid at or after ptr, wrapping modulo n (n <= RR_MAX_REQ).
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                       input logic [2:0]            ptr,
                                       input int                    n);
    rr_pick_t   res;
    logic [2:0] cand;
    res = '0;
    for (int k = 0; k < RR_MAX_REQ; k++) begin
      cand = 3'((int'(ptr) + k) % n);
      if (k < n && !res.found && valid[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker with its rotating pointer; the pointer moves past the
// winner whenever the owner signals that the current pick was taken.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               advance,
  output logic [IW-1:0]      winner,
  output logic               found
);

  logic [IW-1:0] ptr_reg;
  rr_pick_t      pick;

  assign pick   = rr_pick(RR_MAX_REQ'(valid), 3'(ptr_reg), NUM_REQ);
  assign winner = IW'(pick.idx);
  assign found  = pick.found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else if (advance && pick.found) begin
      ptr_reg <= (winner == IW'(NUM_REQ - 1)) ? '0 : winner + IW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte producers: round-robin accept, optional
// channel-tag byte ahead of each payload, and a per-byte completion watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int                    NUM_REQ    = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    TAG_EN     = 1,
  parameter logic [DATA_WIDTH-1:0] TAG_BASE   = DATA_WIDTH'(DEFAULT_TAG_BASE),
  parameter int                    TIMEOUT    = 0,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_busy,
  input  logic                          tx_done,
  output logic [IW-1:0]                 grant_id,
  output logic                          active,
  output logic                          timeout_err
);

  localparam int                WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t            state_reg, state_next;
  logic [DATA_WIDTH-1:0] payload_reg, payload_next;
  logic [IW-1:0]         grant_reg, grant_next;
  logic                  active_reg, active_next;
  logic                  timeout_reg, timeout_next;
  logic [WD_W-1:0]       wd_cnt_reg, wd_cnt_next;

  logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];
  logic [NUM_REQ-1:0]    winner_onehot;
  logic [IW-1:0]         winner;
  logic                  found;
  logic                  in_idle;
  logic                  accept;
  logic                  wd_expire;
  logic [DATA_WIDTH-1:0] tag_byte;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_bytes[gi]     = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign winner_onehot[gi] = (winner == IW'(gi));
    end
  endgenerate

  assign in_idle = (state_reg == IDLE);
  assign accept  = in_idle && found;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (req_valid),
    .advance (accept),
    .winner  (winner),
    .found   (found)
  );

  // rst_n gates ready directly so no handshake can complete while held in reset.
  assign req_ready = (accept && rst_n) ? winner_onehot : '0;

  assign tag_byte  = TAG_BASE | DATA_WIDTH'(grant_reg);
  assign wd_expire = (TIMEOUT != 0) && (wd_cnt_reg == WD_LAST);

  always_comb begin
    state_next   = state_reg;
    payload_next = payload_reg;
    grant_next   = grant_reg;
    active_next  = active_reg;
    timeout_next = 1'b0;
    wd_cnt_next  = '0;
    tx_start     = 1'b0;
    tx_data      = '0;
    unique case (state_reg)
      IDLE: begin
        if (found) begin
          payload_next = req_bytes[winner];
          grant_next   = winner;
          active_next  = 1'b1;
          state_next   = (TAG_EN != 0) ? SEND_TAG : SEND_DATA;
        end
      end
      SEND_TAG: begin
        tx_data  = tag_byte;
        tx_start = !tx_busy;
        if (!tx_busy) state_next = WAIT_TAG;
      end
      WAIT_TAG: begin
        tx_data     = tag_byte;
        wd_cnt_next = wd_cnt_reg + WD_W'(1);
        if (tx_done) begin
          state_next = SEND_DATA;
        end else if (wd_expire) begin
          timeout_next = 1'b1;
          active_next  = 1'b0;
          state_next   = IDLE;
        end
      end
      SEND_DATA: begin
        tx_data  = payload_reg;
        tx_start = !tx_busy;
        if (!tx_busy) state_next = WAIT_DATA;
      end
      WAIT_DATA: begin
        tx_data     = payload_reg;
        wd_cnt_next = wd_cnt_reg + WD_W'(1);
        // A completion in the same cycle as expiry counts as success.
        if (tx_done) begin
          active_next = 1'b0;
          state_next  = IDLE;
        end else if (wd_expire) begin
          timeout_next = 1'b1;
          active_next  = 1'b0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      payload_reg <= '0;
      grant_reg   <= '0;
      active_reg  <= 1'b0;
      timeout_reg <= 1'b0;
      wd_cnt_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      payload_reg <= payload_next;
      grant_reg   <= grant_next;
      active_reg  <= active_next;
      timeout_reg <= timeout_next;
      wd_cnt_reg  <= wd_cnt_next;
    end
  end

  assign grant_id    = grant_reg;
  assign active      = active_reg;
  assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed-plus-random bench for uart_tx_arbiter with a behavioural transmitter
// and a queue-based round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int N       = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 100;
  localparam int FRAME   = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          tx_busy;
  logic          tx_done;
  logic [1:0]    grant_id;
  logic          active;
  logic          timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .TAG_EN     (1),
    .TAG_BASE   (8'hF0),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .active      (active),
    .timeout_err (timeout_err)
  );

  // Behavioural transmitter: busy for FRAME cycles after a start, then a done pulse.
  int   ucnt       = 0;
  bit   done_en    = 1'b1;
  bit   force_busy = 1'b0;
  logic uart_done  = 1'b0;
  int   cyc        = 0;
  int   ready_hi [N] = '{default: 0};

  logic [7:0] sent_q[$];
  int         acc_id_q[$];

  assign tx_busy = (ucnt != 0) || force_busy;
  assign tx_done = uart_done;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    uart_done <= 1'b0;
    if (ucnt != 0) begin
      ucnt <= ucnt - 1;
      if (ucnt == 1) uart_done <= done_en;
    end else if (tx_start) begin
      ucnt <= FRAME;
      sent_q.push_back(tx_data);
      $display("cycle %0d: uart byte 0x%02h", cyc, tx_data);
    end
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) ready_hi[i] <= ready_hi[i] + 1;
        if (req_valid[i] && req_ready[i]) begin
          acc_id_q.push_back(i);
          $display("cycle %0d: accept requester %0d byte 0x%02h", cyc, i, req_data[i*DW +: DW]);
        end
      end
    end
  end

  // Reference model state and scoreboard.
  int         rr_model  = 0;
  int         exp_id_q[$];
  logic [7:0] exp_byte_q[$];
  int         id_chk    = 0;
  int         byte_chk  = 0;
  int         drop_idx  = 0;
  int         n_checks  = 0;
  int         n_fail    = 0;

  int         w, t, c0, ndone, nstart, base_ready, a_base;
  bit         seen_start, tag_bad, hit;
  logic [N-1:0] mask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] m);
    for (int k = 0; k < N; k++) begin
      if (m[(rr_model + k) % N]) return (rr_model + k) % N;
    end
    return -1;
  endfunction

  task automatic expect_one(input logic [N-1:0] m, input bit with_payload, output int win);
    win      = model_pick(m);
    rr_model = (win + 1) % N;
    exp_id_q.push_back(win);
    exp_byte_q.push_back(8'hF0 | 8'(win));
    if (with_payload) exp_byte_q.push_back(req_data[win*DW +: DW]);
  endtask

  task automatic expect_round(input logic [N-1:0] m);
    logic [N-1:0] left;
    int           win;
    left = m;
    while (left != 0) begin
      expect_one(left, 1'b1, win);
      left[win] = 1'b0;
    end
  endtask

  task automatic drop_accepted();
    while (drop_idx < acc_id_q.size()) begin
      req_valid[acc_id_q[drop_idx]] = 1'b0;
      drop_idx++;
    end
  endtask

  task automatic wait_quiet(input string tag, input int max_cyc);
    int  n;
    bit  quiet;
    n     = 0;
    quiet = 1'b0;
    while (!quiet && n < max_cyc) begin
      @(negedge clk);
      n++;
      drop_accepted();
      quiet = !active && !tx_busy && (req_valid == '0);
    end
    chk({tag, "_quiet_in_time"}, 32'(quiet), 32'd1);
  endtask

  task automatic verify(input string tag);
    chk({tag, "_accept_count"}, acc_id_q.size(), exp_id_q.size());
    chk({tag, "_byte_count"}, sent_q.size(), exp_byte_q.size());
    for (int k = id_chk; k < exp_id_q.size(); k++)
      if (k < acc_id_q.size()) chk($sformatf("%s_grant%0d", tag, k), acc_id_q[k], exp_id_q[k]);
    for (int k = byte_chk; k < exp_byte_q.size(); k++)
      if (k < sent_q.size()) chk($sformatf("%s_byte%0d", tag, k), 32'(sent_q[k]), 32'(exp_byte_q[k]));
    id_chk   = exp_id_q.size();
    byte_chk = exp_byte_q.size();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    req_valid = '0;
    req_data  = '0;
    rst_n     = 1'b0;

    // Reset values, with every requester valid so ready must be held low.
    repeat (3) @(negedge clk);
    req_valid = '1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;
    rr_model  = 0;
    @(negedge clk);

    // All four valid continuously: five grants must rotate 0,1,2,3,0.
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int g = 0; g < 5; g++) expect_one(4'hF, 1'b1, w);
    a_base    = acc_id_q.size();
    req_valid = 4'hF;
    t = 0;
    while (acc_id_q.size() < a_base + 5 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    req_valid = '0;
    drop_idx  = acc_id_q.size();
    wait_quiet("cont", 1000);
    verify("cont");

    // Single requester 2: ready for one cycle, start one cycle after accept.
    base_ready = ready_hi[2];
    req_data[2*DW +: DW] = 8'h5A;
    req_valid = 4'b0100;
    expect_round(4'b0100);
    #1;
    chk("single_ready_onehot", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = '0;
    chk("single_ready_after", 32'(req_ready), 32'd0);
    chk("single_start_latency", 32'(tx_start), 32'd1);
    chk("single_tag_byte", 32'(tx_data), 32'hF2);
    chk("single_grant_id", 32'(grant_id), 32'd2);
    chk("single_active", 32'(active), 32'd1);
    ndone = 0;
    t = 0;
    while (ndone < 2 && t < 500) begin
      @(negedge clk);
      t++;
      if (tx_done) ndone++;
    end
    chk("single_two_dones", ndone, 2);
    chk("single_active_at_done", 32'(active), 32'd1);
    @(negedge clk);
    chk("single_active_fall", 32'(active), 32'd0);
    chk("single_ready_cycles", ready_hi[2] - base_ready, 1);
    drop_idx = acc_id_q.size();
    wait_quiet("single", 200);
    verify("single");

    // External busy for 50 cycles after accept: no start, tag held, byte intact.
    force_busy = 1'b1;
    req_data[1*DW +: DW] = 8'($urandom);
    req_valid = 4'b0010;
    expect_round(4'b0010);
    @(negedge clk);
    req_valid  = '0;
    seen_start = 1'b0;
    tag_bad    = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (k != 0) @(negedge clk);
      seen_start |= tx_start;
      tag_bad    |= (tx_data !== 8'hF1);
    end
    chk("busy_no_start", 32'(seen_start), 32'd0);
    chk("busy_tag_held", 32'(tag_bad), 32'd0);
    chk("busy_active", 32'(active), 32'd1);
    force_busy = 1'b0;
    #1;
    chk("busy_release_start", 32'(tx_start), 32'd1);
    chk("busy_release_tag", 32'(tx_data), 32'hF1);
    drop_idx = acc_id_q.size();
    wait_quiet("busy", 300);
    verify("busy");

    // Watchdog: no tx_done, abort 100 cycles after entering WAIT_TAG.
    done_en = 1'b0;
    req_data[0*DW +: DW] = 8'($urandom);
    req_data[3*DW +: DW] = 8'($urandom);
    req_valid = 4'b0001;
    expect_one(4'b0001, 1'b0, w);
    @(negedge clk);
    req_valid = 4'b1000;
    chk("wd_send_tag_start", 32'(tx_start), 32'd1);
    c0  = cyc;
    hit = 1'b0;
    t   = 0;
    while (!hit && t < 400) begin
      @(negedge clk);
      t++;
      hit = timeout_err;
    end
    chk("wd_pulse_seen", 32'(hit), 32'd1);
    chk("wd_delay", cyc - c0, 101);
    chk("wd_active_low", 32'(active), 32'd0);
    expect_round(4'b1000);
    done_en = 1'b1;
    @(negedge clk);
    chk("wd_pulse_width", 32'(timeout_err), 32'd0);
    drop_idx = acc_id_q.size() - 1;
    wait_quiet("wd", 400);
    verify("wd");

    // Random rounds against the reference model.
    for (int r = 0; r < 6; r++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'($urandom);
      req_valid = mask;
      expect_round(mask);
      wait_quiet($sformatf("rand%0d", r), 1500);
      verify($sformatf("rand%0d", r));
    end

    // Asynchronous reset in WAIT_DATA after a grant to requester 0.
    req_data[0*DW +: DW] = 8'($urandom);
    req_valid = 4'b0001;
    expect_one(4'b0001, 1'b1, w);
    @(negedge clk);
    req_valid = 4'b0010;
    nstart = 1;
    t = 0;
    while (nstart < 2 && t < 300) begin
      @(negedge clk);
      t++;
      if (tx_start) nstart++;
    end
    chk("rst_mid_payload_started", nstart, 2);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req_ready", 32'(req_ready), 32'd0);
    chk("arst_tx_start", 32'(tx_start), 32'd0);
    chk("arst_tx_data", 32'(tx_data), 32'd0);
    chk("arst_grant_id", 32'(grant_id), 32'd0);
    chk("arst_active", 32'(active), 32'd0);
    chk("arst_timeout_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    rr_model = 0;
    req_data[0*DW +: DW] = 8'($urandom);
    req_data[1*DW +: DW] = 8'($urandom);
    req_valid = 4'b0011;
    drop_idx  = acc_id_q.size();
    expect_round(4'b0011);
    wait_quiet("after_rst", 1000);
    verify("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
